// File: rtl/matriz_loader.sv
// Streams N*N elements row-major into a packed DIM x DIM matrix register.
// Define MATRIZ_LOADER_CLEAR_EN to zero the whole matrix on each accepted start.
module matriz_loader #(
    parameter int ELEM_W = 8,
    parameter int DIM    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2:0]                size,
    input  logic                      start,
    input  logic [ELEM_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DIM*DIM*ELEM_W-1:0] matriz_out,
    output logic                      out_valid,
    input  logic                      out_ack,
    output logic                      busy,
    output logic                      err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [2:0] DIM_L = 3'(DIM);

    state_t     state;
    state_t     state_nx;
    logic [2:0] n;
    logic [2:0] row;
    logic [2:0] col;
    logic       size_ok;
    logic       accept;
    logic       hs;
    logic       last;

    assign size_ok = (size >= 3'd2) && (size <= DIM_L);
    assign accept  = (state == IDLE) && start && size_ok;
    assign hs      = (state == LOAD) && in_valid;
    assign last    = (row == n - 3'd1) && (col == n - 3'd1);

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = LOAD;
            LOAD: if (hs && last) state_nx = DONE;
            DONE: if (out_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n          <= '0;
            row        <= '0;
            col        <= '0;
            err        <= 1'b0;
            matriz_out <= '0;
        end else begin
            err <= (state == IDLE) && start && !size_ok;
            if (accept) begin
                n   <= size;
                row <= '0;
                col <= '0;
`ifdef MATRIZ_LOADER_CLEAR_EN
                matriz_out <= '0;
`else
                matriz_out <= matriz_out;
`endif
            end
            if (hs) begin
                // Only the addressed (row,col) slot is written; others hold.
                for (int i = 0; i < DIM; i++) begin
                    for (int j = 0; j < DIM; j++) begin
                        if (row == 3'(i) && col == 3'(j)) begin
                            matriz_out[i*DIM*ELEM_W + j*ELEM_W +: ELEM_W] <= in_data;
                        end
                    end
                end
                if (col == n - 3'd1) begin
                    col <= '0;
                    row <= row + 3'd1;
                end else begin
                    col <= col + 3'd1;
                end
            end
        end
    end

endmodule
